// File: rtl/shared_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package shared_pkg;

   // Loader sequencing states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
      DONE    = 3'd3,
      ERROR   = 3'd4
   } boot_state_e;

   // Bytes packed into one instruction word
   localparam int BOOT_WORD_BYTES = 4;

   // Cycles tolerated in COLLECT without an accepted byte
   localparam int DEFAULT_TIMEOUT_CYC = 1024;

   // Width of a counter that must hold values 0..max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and flags the
// byte that completes the word.
module boot_word_packer
   import shared_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   localparam int IDX_W = $clog2(BOOT_WORD_BYTES);

   logic [IDX_W-1:0] idx;

   // The accept that lands on the last byte lane completes the word
   assign word_full = accept && (idx == IDX_W'(BOOT_WORD_BYTES - 1));

   // Byte lane index and word assembly; index wraps naturally after lane 3
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= '0;
         word <= '0;
      end else if (clear) begin
         idx  <= '0;
      end else if (accept) begin
         word[{idx, 3'b000} +: 8] <= byte_in;
         idx                      <= idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory word by word and
// holds the core in reset until the whole image has been written.
module imem_boot_loader
   import shared_pkg::*;
#(
   parameter  int INSTR_MEM_DEPTH = 20,
   parameter  int TIMEOUT_CYC     = DEFAULT_TIMEOUT_CYC,
   localparam int ADDR_W          = $clog2(INSTR_MEM_DEPTH),
   localparam int WC_W            = $clog2(INSTR_MEM_DEPTH + 1)
)(
   input  logic              clk,
   input  logic              RST,
   input  logic              boot_start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              boot_busy,
   output logic              boot_done,
   output logic              boot_err,
   output logic [WC_W-1:0]   word_count
);

   localparam int TO_W = cnt_width(TIMEOUT_CYC - 1);

   boot_state_e       state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [WC_W-1:0]   wc_n;
   logic [TO_W-1:0]   tcnt, tcnt_n;
   logic              accept;
   logic              pk_clear;
   logic              word_full;

   // Handshake decoded from state only, so rx_ready never depends on inputs
   assign rx_ready   = (state == COLLECT);
   assign accept     = rx_ready && rx_valid;
   assign imem_we    = (state == WRITE);
   assign core_rst_n = (state == DONE);
   assign boot_done  = (state == DONE);
   assign boot_err   = (state == ERROR);
   assign boot_busy  = (state == COLLECT) || (state == WRITE);

   boot_word_packer u_packer (
      .clk       (clk),
      .rst       (RST),
      .clear     (pk_clear),
      .accept    (accept),
      .byte_in   (rx_data),
      .word      (imem_wdata),
      .word_full (word_full)
   );

   // State, address, word counter and timeout registers
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         imem_addr  <= '0;
         word_count <= '0;
         tcnt       <= '0;
      end else begin
         state      <= state_n;
         imem_addr  <= addr_n;
         word_count <= wc_n;
         tcnt       <= tcnt_n;
      end
   end

   // Next-state, address/count update and timeout supervision
   always_comb begin
      state_n  = state;
      addr_n   = imem_addr;
      wc_n     = word_count;
      tcnt_n   = tcnt;
      pk_clear = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (boot_start) begin
               state_n  = COLLECT;
               addr_n   = '0;
               wc_n     = '0;
               tcnt_n   = '0;
               pk_clear = 1'b1;
            end
         end
         COLLECT: begin
            if (word_full) begin
               state_n = WRITE;
               tcnt_n  = '0;
            end else if (accept) begin
               tcnt_n  = '0;
            end else if (tcnt == TO_W'(TIMEOUT_CYC - 2)) begin
               // Counter would reach TIMEOUT_CYC-1: abort and drop the partial word
               state_n  = ERROR;
               tcnt_n   = '0;
               pk_clear = 1'b1;
            end else begin
               tcnt_n  = tcnt + TO_W'(1);
            end
         end
         WRITE: begin
            wc_n   = word_count + WC_W'(1);
            tcnt_n = '0;
            if (word_count == WC_W'(INSTR_MEM_DEPTH - 1)) begin
               // Final word: address stays on the last location
               state_n = DONE;
            end else begin
               addr_n  = imem_addr + ADDR_W'(1);
               state_n = COLLECT;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random images checked against
// a word-level reference built from the byte stream.
module tb_imem_boot_loader;

   localparam int DEPTH = 20;
   localparam int TO    = 16;
   localparam int AW    = $clog2(DEPTH);
   localparam int WCW   = $clog2(DEPTH + 1);
   localparam int NB    = DEPTH * 4;

   logic           clk = 1'b0;
   logic           RST = 1'b0;
   logic           boot_start = 1'b0;
   logic [7:0]     rx_data = 8'h00;
   logic           rx_valid = 1'b0;
   logic           rx_ready, imem_we, core_rst_n, boot_busy, boot_done, boot_err;
   logic [AW-1:0]  imem_addr;
   logic [31:0]    imem_wdata;
   logic [WCW-1:0] word_count;

   int n_cmp = 0;
   int n_err = 0;

   imem_boot_loader #(.INSTR_MEM_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .RST(RST), .boot_start(boot_start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst_n(core_rst_n), .boot_busy(boot_busy), .boot_done(boot_done),
      .boot_err(boot_err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          rdy;
      int            cyc;
   } wr_t;

   wr_t         wr_q[$];
   int          acc_cnt  = 0;
   int          cyc      = 0;
   int          rise_cyc = -1;
   logic        prev_crn = 1'b0;
   logic [7:0]  img[NB];
   logic [31:0] exp_w[DEPTH];

   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor: memory writes, accepted bytes, core release edge
   always @(negedge clk) begin
      if (imem_we) wr_q.push_back('{imem_addr, imem_wdata, rx_ready, cyc});
      if (rx_valid && rx_ready) acc_cnt <= acc_cnt + 1;
      if (core_rst_n && !prev_crn) rise_cyc <= cyc;
      prev_crn <= core_rst_n;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference image: word w is bytes 4w..4w+3, little-endian
   task automatic make_image(input bit fixed_first);
      for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
      if (fixed_first) begin
         img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
      end
      for (int w = 0; w < DEPTH; w++)
         exp_w[w] = 32'(img[4*w]) + (32'(img[4*w+1]) << 8) +
                    (32'(img[4*w+2]) << 16) + (32'(img[4*w+3]) << 24);
   endtask

   task automatic pulse_start();
      boot_start = 1'b1;
      step(1);
      boot_start = 1'b0;
   endtask

   // Present bytes lo..hi-1 with random idle gaps; returns after each accept edge
   task automatic send_range(input int lo, input int hi, input int maxgap);
      bit got;
      for (int i = lo; i < hi; i++) begin
         rx_valid = 1'b0;
         step($urandom_range(maxgap, 0));
         rx_valid = 1'b1;
         rx_data  = img[i];
         got = 1'b0;
         for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            got = rx_ready;
            step(1);
         end
         if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL send_byte %0d: rx_ready never rose, need 1", i);
            rx_valid = 1'b0;
            return;
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1 RST = 1'b1;
      #2;
      n_cmp++;
      if ({rx_ready, imem_we, imem_addr, imem_wdata} !== '0) begin
         n_err++; $display("FAIL reset_dp: got %h need 0", {rx_ready, imem_we, imem_addr, imem_wdata});
      end
      n_cmp++;
      if ({core_rst_n, boot_busy, boot_done, boot_err, word_count} !== '0) begin
         n_err++; $display("FAIL reset_status: got %h need 0", {core_rst_n, boot_busy, boot_done, boot_err, word_count});
      end
      step(3);
      RST = 1'b0;
      step(1);
   endtask

   task automatic test_idle_ignore();
      int base = wr_q.size();
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rx_ready !== 1'b0) begin n_err++; $display("FAIL idle_rdy: got %b need 0", rx_ready); end
         step(1);
      end
      rx_valid = 1'b0;
      n_cmp++;
      if (wr_q.size() != base || word_count !== '0) begin
         n_err++; $display("FAIL idle_nowr: writes %0d wc %0d need 0 0", wr_q.size() - base, word_count);
      end
   endtask

   task automatic test_full_image(input int maxgap, input string tag);
      int base  = wr_q.size();
      int abase = acc_cnt;
      pulse_start();
      n_cmp++;
      if (boot_busy !== 1'b1 || core_rst_n !== 1'b0 || boot_done !== 1'b0) begin
         n_err++; $display("FAIL %s_start: busy %b crn %b done %b need 1 0 0", tag, boot_busy, core_rst_n, boot_done);
      end
      send_range(0, NB, maxgap);
      step(3);
      n_cmp++;
      if (wr_q.size() - base != DEPTH) begin
         n_err++; $display("FAIL %s_nwr: got %0d need %0d", tag, wr_q.size() - base, DEPTH);
      end
      for (int i = 0; i < DEPTH && base + i < wr_q.size(); i++) begin
         n_cmp++;
         if (wr_q[base+i].addr !== AW'(i) || wr_q[base+i].data !== exp_w[i] || wr_q[base+i].rdy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_wr%0d: addr %0d data %h rdy %b need %0d %h 0", tag, i,
                     wr_q[base+i].addr, wr_q[base+i].data, wr_q[base+i].rdy, i, exp_w[i]);
         end
      end
      n_cmp++;
      if (acc_cnt - abase != NB) begin
         n_err++; $display("FAIL %s_acc: got %0d need %0d", tag, acc_cnt - abase, NB);
      end
      n_cmp++;
      if (word_count !== WCW'(DEPTH) || boot_done !== 1'b1 || core_rst_n !== 1'b1 || boot_busy !== 1'b0) begin
         n_err++; $display("FAIL %s_done: wc %0d done %b crn %b busy %b need %0d 1 1 0", tag,
                           word_count, boot_done, core_rst_n, boot_busy, DEPTH);
      end
      n_cmp++;
      if (wr_q.size() == 0 || rise_cyc != wr_q[wr_q.size()-1].cyc + 1) begin
         n_err++; $display("FAIL %s_release: rise cyc %0d need last write cyc + 1", tag, rise_cyc);
      end
   endtask

   task automatic test_timeout();
      int base = wr_q.size();
      int k    = 0;
      pulse_start();
      send_range(0, 2, 0);
      while (k <= TO + 2) begin
         @(negedge clk);
         if (boot_err) break;
         k++;
         step(1);
      end
      n_cmp++;
      if (k < TO - 2 || k > TO) begin
         n_err++; $display("FAIL to_delay: err after %0d cycles need %0d..%0d", k, TO - 2, TO);
      end
      step(2);
      n_cmp++;
      if (boot_err !== 1'b1 || core_rst_n !== 1'b0 || boot_busy !== 1'b0 || rx_ready !== 1'b0) begin
         n_err++; $display("FAIL to_state: err %b crn %b busy %b rdy %b need 1 0 0 0", boot_err, core_rst_n, boot_busy, rx_ready);
      end
      n_cmp++;
      if (wr_q.size() != base) begin
         n_err++; $display("FAIL to_nowr: got %0d writes need 0", wr_q.size() - base);
      end
      make_image(1'b0);
      test_full_image(2, "to_reload");
      n_cmp++;
      if (boot_err !== 1'b0) begin n_err++; $display("FAIL to_errclr: got %b need 0", boot_err); end
   endtask

   task automatic test_async_reset();
      int base;
      int snap;
      make_image(1'b0);
      base = wr_q.size();
      pulse_start();
      send_range(0, 30, 1);
      #2 RST = 1'b1;
      #1;
      snap = wr_q.size();
      n_cmp++;
      if ({rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, boot_busy, boot_done, boot_err, word_count} !== '0) begin
         n_err++; $display("FAIL arst_out: got %h need 0",
                           {rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n, boot_busy, boot_done, boot_err, word_count});
      end
      rx_valid = 1'b1;
      step(4);
      rx_valid = 1'b0;
      n_cmp++;
      if (wr_q.size() != snap || snap - base != 7) begin
         n_err++; $display("FAIL arst_wr: before %0d after %0d need 7 0", snap - base, wr_q.size() - snap);
      end
      RST = 1'b0;
      step(1);
      test_full_image(3, "arst_reload");
   endtask

   task automatic test_start_ignored();
      int base;
      make_image(1'b0);
      base = wr_q.size();
      pulse_start();
      send_range(0, 16, 1);
      step(2);
      pulse_start();
      n_cmp++;
      if (boot_busy !== 1'b1 || word_count !== WCW'(4)) begin
         n_err++; $display("FAIL ign_start: busy %b wc %0d need 1 4", boot_busy, word_count);
      end
      send_range(16, NB, 1);
      step(3);
      n_cmp++;
      if (wr_q.size() - base != DEPTH) begin
         n_err++; $display("FAIL ign_nwr: got %0d need %0d", wr_q.size() - base, DEPTH);
      end
      for (int i = 0; i < DEPTH && base + i < wr_q.size(); i++) begin
         n_cmp++;
         if (wr_q[base+i].addr !== AW'(i) || wr_q[base+i].data !== exp_w[i]) begin
            n_err++; $display("FAIL ign_wr%0d: addr %0d data %h need %0d %h", i,
                              wr_q[base+i].addr, wr_q[base+i].data, i, exp_w[i]);
         end
      end
      n_cmp++;
      if (boot_done !== 1'b1 || core_rst_n !== 1'b1) begin
         n_err++; $display("FAIL ign_done: done %b crn %b need 1 1", boot_done, core_rst_n);
      end
      make_image(1'b0);
      test_full_image(0, "done_restart");
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      make_image(1'b1);
      test_full_image(0, "b2b");
      test_full_image(5, "gaps");
      test_timeout();
      test_async_reset();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Hardware loader for the instruction-memory boot image. It receives the image as a byte stream over a valid/ready handshake, for example from a UART receiver or debug link. Every 4 bytes are packed little-endian into a 32-bit instruction word and written to consecutive instruction-memory word addresses. The RISC core is held in reset until exactly INSTR_MEM_DEPTH words have been written, then released.

Parameters:
INSTR_MEM_DEPTH, 20, number of 32-bit instruction words in the boot image and in instruction memory
ADDR_W, $clog2(INSTR_MEM_DEPTH), instruction-memory word-address width (derived; not overridden)
TIMEOUT_CYC, 1024, max cycles in COLLECT without an accepted byte before aborting

Ports:
clk  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
boot_start  in  1  single-cycle request to (re)load the image
rx_data  in  8  incoming image byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction-memory write enable
imem_addr  out  ADDR_W  instruction-memory word address
imem_wdata  out  32  instruction word to write
core_rst_n  out  1  active-low reset to the RISC core; low while not booted
boot_busy  out  1  load in progress
boot_done  out  1  full image written; core running
boot_err  out  1  load aborted by timeout
word_count  out  $clog2(INSTR_MEM_DEPTH+1)  words written so far

Behaviour:
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- RST=1 forces the following values immediately (asynchronous), including mid-load:
  - state IDLE
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - core_rst_n=0, boot_busy=0, boot_done=0, boot_err=0, word_count=0
  - byte index 0, timeout counter 0
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE:
  - rx_ready=0; rx_valid is ignored.
  - boot_start=1 -> COLLECT, with: imem_addr=0, word_count=0, byte index=0, boot_busy=1, boot_err=0, boot_done=0.
- COLLECT:
  - rx_ready=1.
  - A byte is accepted on any edge with rx_valid&&rx_ready. Byte k (k=0..3) goes to imem_wdata[8k+7:8k].
  - Each accepted byte increments the byte index and clears the timeout counter.
  - The 4th accept -> WRITE on the same edge; byte index wraps to 0.
  - Otherwise the timeout counter increments each cycle. Reaching TIMEOUT_CYC-1 -> ERROR; the partial word is discarded.
- WRITE:
  - Lasts exactly 1 cycle: imem_we=1, rx_ready=0; imem_addr and imem_wdata are stable.
  - At the end of the cycle, word_count and imem_addr increment.
  - If word_count+1 == INSTR_MEM_DEPTH -> DONE; else -> COLLECT.
  - Latency: 4th byte accepted at edge N -> imem_we high in the cycle after edge N.
- DONE:
  - core_rst_n=1, boot_done=1, boot_busy=0, rx_ready=0.
  - core_rst_n rises on the edge that leaves the final WRITE cycle.
  - imem_addr holds the last value; it never wraps past INSTR_MEM_DEPTH-1 during writes.
- ERROR:
  - boot_err=1, boot_busy=0, core_rst_n=0, rx_ready=0.
- boot_start handling:
  - Ignored in COLLECT and WRITE.
  - In DONE or ERROR it restarts exactly as from IDLE. From DONE, core_rst_n drops to 0 on the same edge.
- imem_we is never asserted outside WRITE, so no partial word is ever written.

Decomposition:
- shared_pkg holds:
  - boot_state_e enum (IDLE, COLLECT, WRITE, DONE, ERROR)
  - BOOT_WORD_BYTES=4
  - default TIMEOUT_CYC
- One sub-module, boot_word_packer: byte index counter, little-endian shift/pack into a 32-bit register, word_full pulse. The FSM, address counter and timeout stay in imem_boot_loader.

Test Plan:
1. Release RST, pulse boot_start, stream 80 bytes back-to-back; first bytes 0x13,0x00,0x00,0x00 -> imem_we with addr 0, wdata 0x00000013. Expect 20 writes at addr 0..19, word_count=20, boot_done=1, and core_rst_n=1 the cycle after the 20th write.
2. Same image with random 0-5 cycle rx_valid gaps, and bytes presented during WRITE -> identical 20 words. rx_ready=0 in each WRITE cycle; the held byte is accepted next cycle and none is lost or duplicated.
3. TIMEOUT_CYC=16: send 2 bytes then stop -> boot_err=1 within 16 cycles, no imem_we, core_rst_n=0. Then boot_start plus a full image -> writes restart at addr 0, boot_err clears.
4. Assert RST asynchronously (between clock edges) after 7 words -> all outputs take reset values at once with no further imem_we. Then boot_start plus a full image -> 20 writes from addr 0.
5. boot_start pulsed during COLLECT after word 3 -> ignored (word 4 goes to addr 4). boot_start in DONE -> core_rst_n=0 next edge and a reload from addr 0.
6. rx_valid=1 with data while in IDLE -> rx_ready=0, no writes, word_count stays 0.
